// File: rtl/enthdr_tgt_ccc_detector.sv
// Target-side ENTHDR responder: decodes START + broadcast write, ACKs it,
// receives the CCC byte and T-bit, and enters HDR mode on ENTHDR0.
module enthdr_tgt_ccc_detector #(
  parameter logic [6:0] BCAST_ADDR  = 7'h7E,
  parameter logic [7:0] ENTHDR_CODE = 8'h20
) (
  input  logic       i_sdr_clk,
  input  logic       i_sdr_rst,
  input  logic       i_tgt_en,
  input  logic       i_scl,
  input  logic       i_sda,
  input  logic       i_hdr_exit_done,
  output logic       o_sda_low,
  output logic       o_hdr_mode,
  output logic       o_enthdr_done,
  output logic       o_ccc_valid,
  output logic [7:0] o_ccc_code,
  output logic       o_parity_err,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK, CCC, TBIT, CHECK, WAIT_STOP, HDR
  } state_t;

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic        tbit;
  logic        ack_drive;
  logic [1:0]  scl_sync, sda_sync;
  logic        scl_hist, sda_hist;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic parity_ok(input logic [7:0] code, input logic t);
    return t == ~^code;
  endfunction

  // Stage p0..p2: two-flop synchroniser followed by a history flop
  always_ff @(posedge i_sdr_clk) begin
    scl_sync <= {scl_sync[0], i_scl};
    sda_sync <= {sda_sync[0], i_sda};
    scl_hist <= scl_sync[1];
    sda_hist <= sda_sync[1];
  end

  logic scl_s, sda_s, scl_rise, scl_fall, sda_rise, sda_fall, start_c, stop_c;
  assign scl_s    = scl_sync[1];
  assign sda_s    = sda_sync[1];
  assign scl_rise = scl_s & ~scl_hist;
  assign scl_fall = ~scl_s & scl_hist;
  assign sda_rise = sda_s & ~sda_hist;
  assign sda_fall = ~sda_s & sda_hist;
  assign start_c  = sda_fall & scl_s;
  assign stop_c   = sda_rise & scl_s;

  assign o_busy = (state != IDLE) && (state != HDR);

  // Control FSM: enable, STOP and Sr are checked ahead of per-state work
  always_ff @(posedge i_sdr_clk) begin
    if (i_sdr_rst) begin
      state         <= IDLE;
      bit_cnt       <= 4'd0;
      shift         <= 8'h00;
      tbit          <= 1'b0;
      ack_drive     <= 1'b0;
      o_sda_low     <= 1'b0;
      o_hdr_mode    <= 1'b0;
      o_enthdr_done <= 1'b0;
      o_ccc_valid   <= 1'b0;
      o_ccc_code    <= 8'h00;
      o_parity_err  <= 1'b0;
    end else begin
      o_enthdr_done <= 1'b0;
      o_ccc_valid   <= 1'b0;
      o_parity_err  <= 1'b0;
      if (state == HDR) begin
        if (i_hdr_exit_done) begin
          o_hdr_mode <= 1'b0;
          state      <= WAIT_STOP;
        end
      end else if (!i_tgt_en || stop_c) begin
        state     <= IDLE;
        o_sda_low <= 1'b0;
        ack_drive <= 1'b0;
      end else if (start_c) begin
        state     <= ADDR;
        bit_cnt   <= 4'd0;
        o_sda_low <= 1'b0;
        ack_drive <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shift <= {shift[6:0], sda_s};
            if (bit_cnt == 4'd7) begin
              bit_cnt   <= 4'd0;
              ack_drive <= 1'b0;
              state     <= ({shift[6:0], sda_s} == {BCAST_ADDR, 1'b0}) ? ACK : WAIT_STOP;
            end else begin
              bit_cnt <= sat_inc(bit_cnt);
            end
          end
          // First fall opens the ACK slot, second fall closes it
          ACK: if (scl_fall) begin
            if (!ack_drive) begin
              ack_drive <= 1'b1;
              o_sda_low <= 1'b1;
            end else begin
              ack_drive <= 1'b0;
              o_sda_low <= 1'b0;
              bit_cnt   <= 4'd0;
              state     <= CCC;
            end
          end
          CCC: if (scl_rise) begin
            shift <= {shift[6:0], sda_s};
            if (bit_cnt == 4'd7) begin
              bit_cnt <= 4'd0;
              state   <= TBIT;
            end else begin
              bit_cnt <= sat_inc(bit_cnt);
            end
          end
          TBIT: if (scl_rise) begin
            tbit  <= sda_s;
            state <= CHECK;
          end
          CHECK: begin
            if (!parity_ok(shift, tbit)) begin
              o_parity_err <= 1'b1;
              state        <= WAIT_STOP;
            end else if (shift == ENTHDR_CODE) begin
              o_enthdr_done <= 1'b1;
              o_hdr_mode    <= 1'b1;
              o_ccc_code    <= shift;
              state         <= HDR;
            end else begin
              o_ccc_valid <= 1'b1;
              o_ccc_code  <= shift;
              state       <= WAIT_STOP;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
